// File: rtl/gol_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gol_pkg
//  Description : Shared geometry, grid type and cell-index helper for the
//                8x8 Game of Life engine. Cell (r,c) lives at bit 63-8r-c, so
//                row 0 occupies the top byte and column 0 is each row's MSB.
//  Revision    : 1.0  initial release
// ============================================================================
package gol_pkg;

    localparam int GRID_W = 8;
    localparam int GRID_H = 8;

    typedef logic [63:0] grid_t;

    // Flat bit position of cell (r,c) within a grid_t.
    function automatic int cell_idx(input int r, input int c);
        return 63 - 8 * r - c;
    endfunction

endpackage : gol_pkg
`default_nettype wire

// File: rtl/gol_cell.sv
`default_nettype none
// ============================================================================
//  Module      : gol_cell
//  Description : Next-generation logic for one cell under rule B3/S23.
//                Counts the eight Moore neighbours and decides survival/birth.
//  Ports       : alive_i      - current state of this cell
//                neighbours_i - the eight neighbour states (dead beyond edge)
//                next_o       - state of this cell in the next generation
//  Revision    : 1.0  initial release
// ============================================================================
module gol_cell (
    input  logic       alive_i,
    input  logic [7:0] neighbours_i,
    output logic       next_o
);

    logic [3:0] w_count;

    always_comb begin
        w_count = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_count = w_count + {3'd0, neighbours_i[i]};
        end
    end

    // Exactly 3 neighbours gives life whatever the current state; a live
    // cell additionally survives with exactly 2.
    assign next_o = (w_count == 4'd3) || (alive_i && (w_count == 4'd2));

endmodule : gol_cell
`default_nettype wire

// File: rtl/game_of_life.sv
`default_nettype none
// ============================================================================
//  Module      : game_of_life
//  Description : Free-running 8x8 Conway's Game of Life engine. The whole grid
//                is held in one register and advances one generation per
//                clock; all 64 next values are computed in parallel from the
//                current register. Edges do not wrap: off-grid cells are dead.
//  Ports       : clk   - clock, all state changes on the rising edge
//                rst   - synchronous active-high reset, loads INIT
//                state - current (registered) grid, cell (r,c) = bit 63-8r-c
//  Revision    : 1.0  initial release
// ============================================================================
module game_of_life
    import gol_pkg::*;
#(
    parameter logic [63:0] INIT = 64'h4020_E000_0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] state
);

    grid_t state_q;
    grid_t state_d;

    for (genvar r = 0; r < GRID_H; r++) begin : g_row
        for (genvar c = 0; c < GRID_W; c++) begin : g_col
            logic [7:0] w_nbr;

            // k walks the 3x3 window row-major; k==4 is the cell itself and
            // is skipped, so the remaining eight map onto w_nbr[0..7].
            for (genvar k = 0; k < 9; k++) begin : g_nbr
                localparam int NR = r + (k / 3) - 1;
                localparam int NC = c + (k % 3) - 1;
                if (k != 4) begin : g_use
                    localparam int SLOT = (k < 4) ? k : k - 1;
                    if (NR >= 0 && NR < GRID_H && NC >= 0 && NC < GRID_W) begin : g_in
                        assign w_nbr[SLOT] = state_q[cell_idx(NR, NC)];
                    end else begin : g_edge
                        assign w_nbr[SLOT] = 1'b0;
                    end
                end
            end

            gol_cell u_cell (
                .alive_i      (state_q[cell_idx(r, c)]),
                .neighbours_i (w_nbr),
                .next_o       (state_d[cell_idx(r, c)])
            );
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule : game_of_life
`default_nettype wire

// File: tb/tb_game_of_life.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_of_life
//  Description : Directed self-checking bench for game_of_life. Several
//                instances with different seed patterns share clock and reset;
//                hand-computed generations are checked, plus a pseudo-random
//                seed tracked against an independent reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_game_of_life;

    localparam logic [63:0] C_GLIDER  = 64'h4020_E000_0000_0000;
    localparam logic [63:0] C_BLINKER = 64'h0000_0038_0000_0000;
    localparam logic [63:0] C_BLOCK   = 64'h0000_0018_1800_0000;
    localparam logic [63:0] C_EMPTY   = 64'h0000_0000_0000_0000;
    localparam logic [63:0] C_EDGE    = 64'h0101_0100_0000_0000;
    localparam logic [63:0] C_RAND    = 64'hA5C3_5F1E_9B27_D46C;

    logic        clk;
    logic        rst;
    logic [63:0] w_glider;
    logic [63:0] w_blinker;
    logic [63:0] w_block;
    logic [63:0] w_empty;
    logic [63:0] w_edge;
    logic [63:0] w_rand;

    int n_tests;
    int n_fail;

    game_of_life #(.INIT(C_GLIDER))  u_glider  (.clk(clk), .rst(rst), .state(w_glider));
    game_of_life #(.INIT(C_BLINKER)) u_blinker (.clk(clk), .rst(rst), .state(w_blinker));
    game_of_life #(.INIT(C_BLOCK))   u_block   (.clk(clk), .rst(rst), .state(w_block));
    game_of_life #(.INIT(C_EMPTY))   u_empty   (.clk(clk), .rst(rst), .state(w_empty));
    game_of_life #(.INIT(C_EDGE))    u_edge    (.clk(clk), .rst(rst), .state(w_edge));
    game_of_life #(.INIT(C_RAND))    u_rand    (.clk(clk), .rst(rst), .state(w_rand));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: dead boundaries, rule B3/S23, built from (row,col) coordinates.
    function automatic logic [63:0] life_next(input logic [63:0] g);
        logic [63:0] n;
        int          cnt;
        int          rr;
        int          cc;
        logic        alive;
        n = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if ((dr != 0 || dc != 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
                            cnt += int'(g[63 - 8 * rr - cc]);
                    end
                end
                alive = g[63 - 8 * r - c];
                n[63 - 8 * r - c] = (cnt == 3) || (alive && cnt == 2);
            end
        end
        return n;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] m_rand;
        logic [63:0] m_glider;
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;

        // Held reset: every instance sits at its seed.
        repeat (3) step();
        check("rst_glider",  w_glider,  C_GLIDER);
        check("rst_blinker", w_blinker, C_BLINKER);
        check("rst_block",   w_block,   C_BLOCK);
        check("rst_empty",   w_empty,   C_EMPTY);
        check("rst_edge",    w_edge,    C_EDGE);
        check("rst_rand",    w_rand,    C_RAND);
        step();
        check("rst_hold",    w_glider,  C_GLIDER);

        rst    = 1'b0;
        m_rand = C_RAND;
        for (int gen = 1; gen <= 100; gen++) begin
            step();
            m_rand = life_next(m_rand);
            check("rand", w_rand, m_rand);
            check("empty", w_empty, C_EMPTY);
            if (gen <= 10) check("block", w_block, C_BLOCK);
            if (gen == 1) begin
                check("glider_g1",  w_glider,  64'h00A0_6040_0000_0000);
                check("blinker_g1", w_blinker, 64'h0000_1010_1000_0000);
                check("edge_g1",    w_edge,    64'h0003_0000_0000_0000);
            end
            if (gen == 2) check("blinker_g2", w_blinker, C_BLINKER);
            if (gen == 4) check("glider_g4",  w_glider,  64'h0020_1070_0000_0000);
        end

        // Reset mid-run: glider reloads and evolution restarts from the seed.
        rst = 1'b1;
        step();
        rst      = 1'b0;
        m_glider = C_GLIDER;
        for (int i = 0; i < 3; i++) begin
            step();
            m_glider = life_next(m_glider);
            check("glider_run", w_glider, m_glider);
        end
        rst = 1'b1;
        step();
        check("midrst_init", w_glider, C_GLIDER);
        rst = 1'b0;
        step();
        check("midrst_g1", w_glider, 64'h00A0_6040_0000_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_game_of_life
`default_nettype wire
